// File: rtl/line_clear_unit.sv
// Post-lock line-clear engine: drops full rows, compacts the board
// downward, zero-fills vacated top rows and pulses the cleared count.
module line_clear_unit #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int ROW_AW = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ROW_AW-1:0] rd_addr,
  input  logic [COLS-1:0]   rd_data,
  output logic              wr_en,
  output logic [ROW_AW-1:0] wr_addr,
  output logic [COLS-1:0]   wr_data,
  output logic              done,
  output logic [2:0]        num_lines
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [ROW_AW-1:0] LAST = ROW_AW'(ROWS - 1);

  state_t            state;
  logic [ROW_AW-1:0] r;
  logic [ROW_AW-1:0] w;
  logic [2:0]        k;
  logic [2:0]        k_nxt;
  logic              full;

  assign full = &rd_data;

  always_comb begin
    k_nxt = k;
    if (full && k != 3'd7)
      k_nxt = k + 3'd1;
  end

  // Writes depend on the row just read, so they leave the block
  // in the same EVAL cycle that rd_data is valid.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    unique case (1'b1)
      (state == S_EVAL) && !full: begin
        wr_en   = 1'b1;
        wr_addr = w;
        wr_data = rd_data;
      end
      (state == S_CLEAR): begin
        wr_en   = 1'b1;
        wr_addr = w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      done      <= 1'b0;
      num_lines <= '0;
      r         <= '0;
      w         <= '0;
      k         <= '0;
    end else begin
      rd_en     <= 1'b0;
      done      <= 1'b0;
      num_lines <= '0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            r       <= LAST;
            w       <= LAST;
            k       <= '0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= LAST;
            state   <= S_READ;
          end
        end
        S_READ: state <= S_EVAL;
        S_EVAL: begin
          k <= k_nxt;
          if (!full)
            w <= w - 1'b1;
          if (r != '0) begin
            r       <= r - 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= r - 1'b1;
            state   <= S_READ;
          end else if (k_nxt != '0) begin
            state <= S_CLEAR;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        // Clear until row 0 so compaction stays exact past saturation.
        S_CLEAR: begin
          w <= w - 1'b1;
          if (w == '0) begin
            done      <= 1'b1;
            num_lines <= k;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_unit.sv
// Bench for line_clear_unit: board RAM, list-based compaction model
// and a per-cycle compare of busy/done/num_lines.
module tb_line_clear_unit;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            start = 1'b0;
  logic            busy;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;
  logic [COLS-1:0] rd_data = '0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [COLS-1:0] wr_data;
  logic            done;
  logic [2:0]      num_lines;

  line_clear_unit #(.ROWS(ROWS), .COLS(COLS), .ROW_AW(AW)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .done     (done),
    .num_lines(num_lines)
  );

  always #10 CLK = ~CLK;

  logic [COLS-1:0] board [32];
  logic [COLS-1:0] exp_b [ROWS];

  always @(posedge CLK) begin
    if (rd_en) rd_data <= board[rd_addr];
    if (wr_en) board[wr_addr] <= wr_data;
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int active = 0;
  int c0 = 0;
  int c_end = -1;
  int done_en = 0;
  int exp_cnt = 0;
  int done_seen = 0;
  int got_nl = -1;
  int got_rel = -1;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    logic eb, ed;
    logic [2:0] en;
    eb = (active != 0) && cyc >= c0 && cyc <= c_end;
    ed = (active != 0) && (done_en != 0) && cyc == c_end;
    en = ed ? 3'(exp_cnt) : 3'd0;
    tests++;
    if (busy !== eb || done !== ed || num_lines !== en) begin
      fails++;
      $display("FAIL cycle_check cyc=%0d busy=%b exp=%b done=%b exp=%b num_lines=%0d exp=%0d",
               cyc, busy, eb, done, ed, num_lines, en);
    end
    tests++;
    if (rd_en === 1'b1 && wr_en === 1'b1) begin
      fails++;
      $display("FAIL rw_overlap cyc=%0d rd_en=%b wr_en=%b required not both", cyc, rd_en, wr_en);
    end
    if (done === 1'b1) begin
      done_seen++;
      got_nl  = int'(num_lines);
      got_rel = cyc - c0 + 1;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int i = 0; i < 32; i++) board[i] = '0;
  endtask

  // Model: keep non-full rows in bottom-up order, pack them at the
  // bottom, zero the rest; count saturates at 7.
  task automatic run_scan(input string nm, input int p1, input int p2, input int ab);
    int full, n, lat, bad;
    logic [COLS-1:0] q[$];
    full = 0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (&board[i]) full++;
      else q.push_back(board[i]);
    end
    for (int i = 0; i < ROWS; i++) exp_b[i] = '0;
    n = 0;
    foreach (q[j]) begin
      exp_b[ROWS - 1 - n] = q[j];
      n++;
    end
    lat = 2 * ROWS + full + 1;
    @(negedge CLK);
    exp_cnt = (full > 7) ? 7 : full;
    c0 = cyc + 1;
    c_end = c0 + lat - 1;
    done_en = 1;
    active = 1;
    done_seen = 0;
    got_rel = -1;
    got_nl = -1;
    start = 1'b1;
    for (int j = 0; j < lat + 3; j++) begin
      int rel;
      @(negedge CLK);
      rel = cyc - c0 + 1;
      start = (rel == p1 || rel == p2) ? 1'b1 : 1'b0;
      if (ab != 0 && rel == ab) begin
        RESET = 1'b1;
        c_end = cyc;
        done_en = 0;
      end else begin
        RESET = 1'b0;
      end
      if (ab != 0 && rel == ab + 1) begin
        tests++;
        if (rd_en !== 1'b0 || wr_en !== 1'b0 || rd_addr !== '0 ||
            wr_addr !== '0 || wr_data !== '0) begin
          fails++;
          $display("FAIL %s_abort_outs rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%h required all 0",
                   nm, rd_en, wr_en, rd_addr, wr_addr, wr_data);
        end
      end
    end
    start = 1'b0;
    RESET = 1'b0;
    if (ab != 0) begin
      chk({nm, "_done_count"}, done_seen, 0);
    end else begin
      chk({nm, "_done_count"}, done_seen, 1);
      bad = 0;
      for (int i = 0; i < ROWS; i++)
        if (board[i] !== exp_b[i]) begin
          if (bad == 0)
            $display("FAIL %s_board row=%0d got=%h required=%h", nm, i, board[i], exp_b[i]);
          bad++;
        end
      tests++;
      if (bad != 0) fails++;
    end
  endtask

  task automatic rand_board(input int maxfull);
    int nf;
    nf = 0;
    for (int i = 0; i < ROWS; i++) begin
      if ($urandom_range(3) == 0 && nf < maxfull) begin
        board[i] = '1;
        nf++;
      end else begin
        board[i] = COLS'($urandom) & 10'h3FE;
        if ($urandom_range(1) == 0) board[i] = '0;
      end
    end
  endtask

  initial begin
    clear_board();
    repeat (3) @(negedge CLK);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_wr_addr", int'(wr_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    chk("reset_num_lines", int'(num_lines), 0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    clear_board();
    run_scan("empty", 0, 0, 0);
    chk("empty_latency", got_rel, 41);
    chk("empty_lines", got_nl, 0);

    clear_board();
    board[19] = 10'h3FF;
    board[18] = 10'h001;
    run_scan("one_row", 0, 0, 0);
    chk("one_row_lines", got_nl, 1);
    chk("one_row_r19", int'(board[19]), 'h001);
    chk("one_row_r0", int'(board[0]), 0);

    clear_board();
    for (int i = 16; i < 20; i++) board[i] = 10'h3FF;
    board[15] = 10'h155;
    run_scan("four_rows", 0, 0, 0);
    chk("four_rows_lines", got_nl, 4);
    chk("four_rows_latency", got_rel, 45);
    chk("four_rows_r19", int'(board[19]), 'h155);
    chk("four_rows_r3", int'(board[3]), 0);

    clear_board();
    board[19] = 10'h3FF;
    board[17] = 10'h3FF;
    board[18] = 10'h0F0;
    board[16] = 10'h00F;
    run_scan("split", 0, 0, 0);
    chk("split_lines", got_nl, 2);
    chk("split_r19", int'(board[19]), 'h0F0);
    chk("split_r18", int'(board[18]), 'h00F);

    rand_board(7);
    run_scan("repulse", 5, 20, 0);

    rand_board(7);
    run_scan("abort", 0, 0, 10);
    repeat (2) @(negedge CLK);
    rand_board(7);
    run_scan("after_abort", 0, 0, 0);

    clear_board();
    for (int i = 0; i < 10; i++) board[2 * i + 1] = 10'h3FF;
    for (int i = 0; i < 10; i++) board[2 * i] = COLS'(i + 1);
    run_scan("saturate", 0, 0, 0);
    chk("saturate_lines", got_nl, 7);

    for (int t = 0; t < 25; t++) begin
      rand_board(7);
      run_scan("random", 0, 0, 0);
      repeat ($urandom_range(2)) @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
